link_serial_ctrl: RTL
=====================

// Module: link_serial_ctrl
// PURPOSE
//  Link-port serial controller: CPU-visible SB shift register + SC control, one shift per bit clock.
//  Internal-clock (master) and external-clock (slave) modes; data width and clock rates parametrised.
//  Adds CGB fast-clock select, an input synchroniser, abort and restart semantics, and exact bit counting.
//  Sits between the CPU register decode (SB/SC selects) and the link cable pins; IRQ goes to the interrupt controller.
// PARAMETERS
//  DATA_W        8    shift register width, 4..32; bits per transfer
//  CLK_DIV_SLOW  256  internal-clock half period in clk cycles, normal speed; must be >= 2
//  CLK_DIV_FAST  8    internal-clock half period in clk cycles, fast speed; must be >= 2
//  SYNC_STAGES   2    flops on serial_clk_in/serial_data_in, 2..4
// PORTS
//  clk              in   1       system clock
//  rst_n            in   1       async active-low reset
//  sel_sc           in   1       SC register selected
//  sel_sb           in   1       SB register selected
//  cpu_wr_n         in   1       CPU write strobe, active low
//  sc_start_in      in   1       SC bit 7 write data
//  sc_int_clock_in  in   1       SC bit 0 write data (1 = internal clock)
//  sc_fast_in       in   1       SC bit 1 write data (1 = fast clock)
//  sb_in            in   DATA_W  SB write data
//  serial_clk_in    in   1       cable clock, async
//  serial_data_in   in   1       cable data, async
//  serial_clk_out   out  1       cable clock driven in internal mode
//  serial_data_out  out  1       cable data (current MSB)
//  sb               out  DATA_W  SB readback
//  serial_irq       out  1       one-cycle transfer-complete pulse
//  sc_start         out  1       transfer in progress (SC bit 7)
//  sc_int_clock     out  1       SC bit 0 readback
//  sc_fast          out  1       SC bit 1 readback
// BEHAVIOUR
//  Reset: sb=0, sc_start=0, sc_int_clock=0, sc_fast=0, serial_clk_out=1, serial_data_out=1, serial_irq=0, FSM=IDLE.
//  Writes: sel_sc&&!cpu_wr_n has priority over sel_sb. SB writes are ignored while sc_start=1.
//  SC write: latches start/int_clock/fast next cycle. start=1 loads bit_cnt=DATA_W, div=HALF-1 and serial_clk_out=1,
//  then enters INT_LO or EXT; it restarts a transfer if one is running. start=0 aborts: back to IDLE, serial_clk_out=1, no IRQ, sb kept.
//  HALF = sc_fast ? CLK_DIV_FAST : CLK_DIV_SLOW. The div counter is clog2(max)+1 bits wide and wraps to HALF-1 at 0.
//  FSM states: IDLE, INT_LO, INT_HI, EXT, DONE.
//  INT_LO: serial_clk_out=0 and serial_data_out=sb[DATA_W-1] from the first cycle. After HALF cycles: -> INT_HI,
//   serial_clk_out=1, sb<={sb[DATA_W-2:0],sync_data}, bit_cnt-1.
//  INT_HI: after HALF cycles: -> INT_LO if bit_cnt!=0, else -> DONE.
//  Timing: SC write at cycle T gives the first falling edge at T+1, rising edges at T+1+HALF*(2k+1),
//   and the IRQ at T+1+2*HALF*DATA_W.
//  EXT: serial_clk_in and serial_data_in pass through SYNC_STAGES flops; edges are detected on the synchronised clock.
//   Falling edge: serial_data_out<=sb[DATA_W-1]. Rising edge: shift in sync_data, bit_cnt-1; if bit_cnt hits 0 -> DONE.
//   Edges are counted only on the rising edge, so exactly DATA_W rising edges complete a transfer.
//  DONE (1 cycle): serial_irq=1, sc_start=0, bit_cnt=DATA_W -> IDLE. serial_data_out holds the last value.
//  An SC write in the DONE cycle wins: no IRQ, new transfer or abort applies.
//  Switching int_clock via an SC write with start=1 mid-transfer restarts in the new mode.
//  Reset asserted mid-transfer: immediate return to reset values, no IRQ.
// CONFIGURATION
//  LINK_FAST_CLK_EN defined: the sc_fast register exists and HALF follows sc_fast as above.
//  LINK_FAST_CLK_EN undefined: sc_fast_in ignored, sc_fast tied 0, HALF=CLK_DIV_SLOW always, CLK_DIV_FAST unused.
// TESTING
//  Internal slow: DATA_W=8, CLK_DIV_SLOW=4, sb_in=0xA5, SC start+int; loop data_out->data_in
//   -> 8 clk_out pulses of period 8, sb=0xA5 and IRQ at T+65.
//  Fast (LINK_FAST_CLK_EN): CLK_DIV_FAST=2, sc_fast_in=1, serial_data_in=1
//   -> period 4, sb=0xFF, IRQ at T+33; without the macro -> sc_fast=0, period 8.
//  External: sb=0x3C; drive 8 clk_in pulses of 10 cycles low/high with data 0xC3 MSB-first
//   -> data_out sequence 0,0,1,1,1,1,0,0; sb=0xC3; one IRQ after the 8th rising edge + SYNC_STAGES+1.
//  Abort: start internal, write SC start=0 after 3 bits -> clk_out=1, no IRQ, sc_start=0; a later SB write of 0x11 reads back 0x11.
//  Collisions: SB write during transfer -> ignored; sel_sc & sel_sb same cycle -> only SC applied;
//   SC start=1 in the DONE cycle -> no IRQ, new transfer.
//  Reset: rst_n low at bit 5 of an internal transfer -> all outputs at reset values next cycle; no IRQ after release.

Source files
------------

// File: rtl/link_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : link_serial_ctrl
//  Purpose  : Link-port serial controller. A CPU-visible SB shift register and
//             SC control register shift one bit per serial clock. The serial
//             clock is either generated here (internal/master) or taken from
//             the cable (external/slave).
//  Config   : LINK_FAST_CLK_EN - when defined, SC bit 1 selects the fast
//             internal clock (CLK_DIV_FAST). When undefined, sc_fast reads 0
//             and the internal clock always uses CLK_DIV_SLOW.
//  Revision : 1.0 - initial release
// ============================================================================
module link_serial_ctrl #(
  parameter int DATA_W       = 8,
  parameter int CLK_DIV_SLOW = 256,
  parameter int CLK_DIV_FAST = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_sc,
  input  logic              sel_sb,
  input  logic              cpu_wr_n,
  input  logic              sc_start_in,
  input  logic              sc_int_clock_in,
  input  logic              sc_fast_in,
  input  logic [DATA_W-1:0] sb_in,
  input  logic              serial_clk_in,
  input  logic              serial_data_in,
  output logic              serial_clk_out,
  output logic              serial_data_out,
  output logic [DATA_W-1:0] sb,
  output logic              serial_irq,
  output logic              sc_start,
  output logic              sc_int_clock,
  output logic              sc_fast
);

  // Divider is wide enough for the larger half period plus one spare bit.
  localparam int DIV_MAX = (CLK_DIV_SLOW > CLK_DIV_FAST) ? CLK_DIV_SLOW : CLK_DIV_FAST;
  localparam int DIV_W   = $clog2(DIV_MAX) + 1;
  localparam int CNT_W   = $clog2(DATA_W) + 1;

  localparam logic [CNT_W-1:0] C_BITS      = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [DIV_W-1:0] C_DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] C_SLOW_M1   = DIV_W'(CLK_DIV_SLOW - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INT_LO = 3'd1,
    INT_HI = 3'd2,
    EXT    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sb_q, sb_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                clk_out_q, clk_out_d;
  logic                data_out_q, data_out_d;
  logic                start_q, start_d;
  logic                int_clk_q, int_clk_d;
  logic                fast_rd;

  // Cable input synchronisers plus the previous synchronised clock level.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sdat_sync_q, sdat_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;

  logic                sclk_s;
  logic                sdat_s;
  logic                sclk_rise;
  logic                sclk_fall;
  logic                sc_wr;
  logic                sb_wr;
  logic [DATA_W-1:0]   sb_shift;
  logic [DIV_W-1:0]    run_half_m1;
  logic [DIV_W-1:0]    start_half_m1;

  // SC access has priority; SB writes are locked out while a transfer runs.
  assign sc_wr = sel_sc && !cpu_wr_n;
  assign sb_wr = sel_sb && !cpu_wr_n && !sc_wr && !start_q;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdat_s    = sdat_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s && !sclk_prev_q;
  assign sclk_fall = !sclk_s && sclk_prev_q;
  assign sb_shift  = {sb_q[DATA_W-2:0], sdat_s};

`ifdef LINK_FAST_CLK_EN
  localparam logic [DIV_W-1:0] C_FAST_M1 = DIV_W'(CLK_DIV_FAST - 1);

  logic fast_q, fast_d;

  // Fast-clock select register, updated by every SC write.
  always_comb begin
    fast_d = fast_q;
    if (sc_wr) begin
      fast_d = sc_fast_in;
    end
  end

  // Fast-clock select flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_q <= 1'b0;
    end else begin
      fast_q <= fast_d;
    end
  end

  assign fast_rd       = fast_q;
  assign run_half_m1   = fast_q ? C_FAST_M1 : C_SLOW_M1;
  // A start write uses the speed being written in the same access.
  assign start_half_m1 = sc_fast_in ? C_FAST_M1 : C_SLOW_M1;
`else
  logic unused_fast_in;
  assign unused_fast_in = sc_fast_in;
  assign fast_rd        = 1'b0;
  assign run_half_m1    = C_SLOW_M1;
  assign start_half_m1  = C_SLOW_M1;
`endif

  // Shift the cable clock and data through the synchroniser chains.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], serial_clk_in};
    sdat_sync_d = {sdat_sync_q[SYNC_STAGES-2:0], serial_data_in};
    sclk_prev_d = sclk_s;
  end

  // Next-state logic: bit timing per state, then CPU writes override it.
  always_comb begin
    state_d    = state_q;
    sb_d       = sb_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    data_out_d = data_out_q;
    start_d    = start_q;
    int_clk_d  = int_clk_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end

      INT_LO: begin
        if (div_q == '0) begin
          // End of the low phase: rising edge samples the cable data.
          state_d   = INT_HI;
          div_d     = run_half_m1;
          sb_d      = sb_shift;
          bit_cnt_d = bit_cnt_q - C_CNT_ONE;
        end else begin
          div_d = div_q - C_DIV_ONE;
        end
      end

      INT_HI: begin
        if (div_q == '0) begin
          div_d = run_half_m1;
          if (bit_cnt_q != '0) begin
            // Falling edge: present the next MSB on the cable.
            state_d    = INT_LO;
            data_out_d = sb_q[DATA_W-1];
          end else begin
            state_d = DONE;
            start_d = 1'b0;
          end
        end else begin
          div_d = div_q - C_DIV_ONE;
        end
      end

      EXT: begin
        if (sclk_fall) begin
          data_out_d = sb_q[DATA_W-1];
        end else if (sclk_rise) begin
          // Only rising edges count bits, so DATA_W rises end the transfer.
          sb_d      = sb_shift;
          bit_cnt_d = bit_cnt_q - C_CNT_ONE;
          if (bit_cnt_q == C_CNT_ONE) begin
            state_d = DONE;
            start_d = 1'b0;
          end
        end
      end

      DONE: begin
        state_d   = IDLE;
        bit_cnt_d = C_BITS;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (sc_wr) begin
      // An SC write restarts or aborts whatever is in progress, DONE included.
      sb_d      = sb_q;
      start_d   = sc_start_in;
      int_clk_d = sc_int_clock_in;
      if (sc_start_in) begin
        bit_cnt_d = C_BITS;
        div_d     = start_half_m1;
        if (sc_int_clock_in) begin
          state_d    = INT_LO;
          data_out_d = sb_q[DATA_W-1];
        end else begin
          state_d = EXT;
        end
      end else begin
        state_d = IDLE;
      end
    end else if (sb_wr) begin
      sb_d = sb_in;
    end

    // The generated clock is low only while in the low phase.
    clk_out_d = (state_d != INT_LO);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sb_q        <= '0;
      bit_cnt_q   <= C_BITS;
      div_q       <= C_SLOW_M1;
      clk_out_q   <= 1'b1;
      data_out_q  <= 1'b1;
      start_q     <= 1'b0;
      int_clk_q   <= 1'b0;
      sclk_sync_q <= '1;
      sdat_sync_q <= '1;
      sclk_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      clk_out_q   <= clk_out_d;
      data_out_q  <= data_out_d;
      start_q     <= start_d;
      int_clk_q   <= int_clk_d;
      sclk_sync_q <= sclk_sync_d;
      sdat_sync_q <= sdat_sync_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  // A same-cycle SC write suppresses the completion pulse.
  assign serial_irq      = (state_q == DONE) && !sc_wr;
  assign serial_clk_out  = clk_out_q;
  assign serial_data_out = data_out_q;
  assign sb              = sb_q;
  assign sc_start        = start_q;
  assign sc_int_clock    = int_clk_q;
  assign sc_fast         = fast_rd;

endmodule
`default_nettype wire
